// File: rtl/fp_loader_pkg.sv
// Shared FSM state, ALU operation codes and phase encodings for fp_operand_loader.
package fp_loader_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] PH_LOAD_A = 2'b00;
    localparam logic [1:0] PH_LOAD_B = 2'b01;
    localparam logic [1:0] PH_EXEC   = 2'b10;
    localparam logic [1:0] PH_DONE   = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus symmetric debouncer for a raw push-button.
// level_o follows the synchronized input after DEBOUNCE_CYCLES stable samples; rise_o pulses once per accepted press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            rise_q <= 1'b0;
            // cnt_q counts consecutive samples that disagree with the current level
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                rise_q  <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/fp_operand_loader.sv
// Hex-keypad operand loader: assembles two operands nibble by nibble and hands them to an ALU.
// Define FP_LOADER_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYCLES.
module fp_operand_loader
    import fp_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        nibble_i,
    input  logic                              enter_i,
    input  logic                              clr_i,
    input  logic [1:0]                        op_i,
    input  logic                              result_valid_i,
    output logic [DATA_WIDTH-1:0]             a_o,
    output logic [DATA_WIDTH-1:0]             b_o,
    output logic [1:0]                        op_o,
    output logic                              start_o,
    output logic                              busy_o,
    output logic [1:0]                        phase_o,
    output logic [$clog2(DATA_WIDTH/4)-1:0]   digit_idx_o,
    output logic                              timeout_o
);

    localparam int unsigned DIGITS = DATA_WIDTH / 4;
    localparam int unsigned IDX_W  = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [1:0]            op_q;
    logic                  start_q;
    logic                  busy_q;
    logic [1:0]            phase_q;
    logic [IDX_W-1:0]      idx_q;

    logic btn_level;
    logic btn_rise;
    logic press;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .btn_i  (enter_i),
        .level_o(btn_level),
        .rise_o (btn_rise)
    );

    assign press = btn_rise & btn_level;

`ifdef FP_LOADER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q;
    logic             timeout_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            phase_q <= PH_LOAD_A;
            idx_q   <= '0;
`ifdef FP_LOADER_TIMEOUT_EN
            tmo_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            // clr_i outranks everything, so a press landing in the same cycle is dropped
            if (clr_i) begin
                state_q <= LOAD_A;
                a_q     <= '0;
                b_q     <= '0;
                busy_q  <= 1'b0;
                phase_q <= PH_LOAD_A;
                idx_q   <= '0;
`ifdef FP_LOADER_TIMEOUT_EN
                tmo_q     <= '0;
                timeout_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    LOAD_A: begin
                        if (press) begin
                            a_q <= {a_q[DATA_WIDTH-5:0], nibble_i};
                            if (idx_q == IDX_LAST) begin
                                idx_q   <= '0;
                                state_q <= LOAD_B;
                                phase_q <= PH_LOAD_B;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                    LOAD_B: begin
                        if (press) begin
                            b_q <= {b_q[DATA_WIDTH-5:0], nibble_i};
                            if (idx_q == IDX_LAST) begin
                                idx_q   <= '0;
                                state_q <= ISSUE;
                                phase_q <= PH_EXEC;
                                busy_q  <= 1'b1;
                                start_q <= 1'b1;
                                op_q    <= op_i;
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        state_q <= WAIT;
`ifdef FP_LOADER_TIMEOUT_EN
                        tmo_q <= '0;
`endif
                    end
                    WAIT: begin
                        if (result_valid_i) begin
                            state_q <= DONE;
                            phase_q <= PH_DONE;
                            busy_q  <= 1'b0;
                        end
`ifdef FP_LOADER_TIMEOUT_EN
                        else if (tmo_q == TMO_LAST) begin
                            state_q   <= DONE;
                            phase_q   <= PH_DONE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
`endif
                    end
                    DONE: begin
                        if (press) begin
                            state_q <= LOAD_A;
                            phase_q <= PH_LOAD_A;
                            a_q     <= '0;
                            b_q     <= '0;
                            idx_q   <= '0;
`ifdef FP_LOADER_TIMEOUT_EN
                            timeout_q <= 1'b0;
`endif
                        end
                    end
                    default: begin
                        state_q <= LOAD_A;
                        phase_q <= PH_LOAD_A;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign op_o        = op_q;
    assign start_o     = start_q;
    assign busy_o      = busy_q;
    assign phase_o     = phase_q;
    assign digit_idx_o = idx_q;

`ifdef FP_LOADER_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fp_operand_loader.sv
// Directed bench for fp_operand_loader; issued operands are checked through a start_o scoreboard.
module tb_fp_operand_loader;

    localparam int unsigned DW  = 32;
    localparam int unsigned DEB = 16;
    localparam int unsigned TMO = 64;

    logic          clk;
    logic          reset;
    logic [3:0]    nibble_i;
    logic          enter_i;
    logic          clr_i;
    logic [1:0]    op_i;
    logic          result_valid_i;
    logic [DW-1:0] a_o;
    logic [DW-1:0] b_o;
    logic [1:0]    op_o;
    logic          start_o;
    logic          busy_o;
    logic [1:0]    phase_o;
    logic [2:0]    digit_idx_o;
    logic          timeout_o;

    fp_operand_loader #(
        .DATA_WIDTH     (DW),
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .nibble_i      (nibble_i),
        .enter_i       (enter_i),
        .clr_i         (clr_i),
        .op_i          (op_i),
        .result_valid_i(result_valid_i),
        .a_o           (a_o),
        .b_o           (b_o),
        .op_o          (op_o),
        .start_o       (start_o),
        .busy_o        (busy_o),
        .phase_o       (phase_o),
        .digit_idx_o   (digit_idx_o),
        .timeout_o     (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
    } issue_t;

    issue_t sb_q[$];
    int n_cmp   = 0;
    int n_err   = 0;
    int n_start = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (start_o === 1'b1) begin
            issue_t e;
            n_start++;
            if (sb_q.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("issue_a", a_o, e.a);
                check("issue_b", b_o, e.b);
                check("issue_op", 32'(op_o), 32'(e.op));
                check("issue_busy", 32'(busy_o), 32'd1);
            end
        end
    end

    task automatic press(input logic [3:0] n);
        nibble_i = n;
        enter_i  = 1'b1;
        repeat (DEB + 4) @(negedge clk);
        enter_i = 1'b0;
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic load(input logic [31:0] v);
        for (int unsigned i = 0; i < 8; i++) press(v[31 - 4*i -: 4]);
    endtask

    task automatic pulse_rv();
        result_valid_i = 1'b1;
        @(negedge clk);
        result_valid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a"}, a_o, 32'd0);
        check({tag, "_b"}, b_o, 32'd0);
        check({tag, "_op"}, 32'(op_o), 32'd0);
        check({tag, "_start"}, 32'(start_o), 32'd0);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_phase"}, 32'(phase_o), 32'd0);
        check({tag, "_idx"}, 32'(digit_idx_o), 32'd0);
        check({tag, "_tmo"}, 32'(timeout_o), 32'd0);
    endtask

    initial begin
        int starts_before;
        reset          = 1'b1;
        nibble_i       = 4'h0;
        enter_i        = 1'b0;
        clr_i          = 1'b0;
        op_i           = 2'b00;
        result_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // operation 1: add of two single-precision patterns
        pulse_rv();
        check("rv_ignored_phase", 32'(phase_o), 32'h0);
        press(4'h4); press(4'h1); press(4'h4);
        check("a_idx3", 32'(digit_idx_o), 32'd3);
        check("a_partial", a_o, 32'h0000_0414);
        press(4'h4); press(4'hC); press(4'hC); press(4'hC); press(4'hD);
        check("a_done_phase", 32'(phase_o), 32'h1);
        check("a_done_idx", 32'(digit_idx_o), 32'd0);
        check("a_value", a_o, 32'h4144_CCCD);
        sb_q.push_back('{a: 32'h4144_CCCD, b: 32'h4059_999A, op: 2'b00});
        load(32'h4059_999A);
        check("op1_phase", 32'(phase_o), 32'h2);
        check("op1_busy", 32'(busy_o), 32'd1);
        check("op1_op", 32'(op_o), 32'h0);
        check("op1_b", b_o, 32'h4059_999A);
        check("op1_starts", 32'(n_start), 32'd1);
        press(4'h7);
        check("wait_ignores_press", b_o, 32'h4059_999A);
        pulse_rv();
        check("done_phase", 32'(phase_o), 32'h3);
        check("done_busy", 32'(busy_o), 32'd0);
        check("done_a_hold", a_o, 32'h4144_CCCD);
        press(4'h0);
        check("restart_a", a_o, 32'd0);
        check("restart_phase", 32'(phase_o), 32'h0);

        // short glitch is rejected, long hold accepts exactly one digit
        nibble_i = 4'h9;
        enter_i  = 1'b1;
        repeat (DEB - 2) @(negedge clk);
        enter_i = 1'b0;
        repeat (DEB + 4) @(negedge clk);
        check("glitch_idx", 32'(digit_idx_o), 32'd0);
        check("glitch_a", a_o, 32'd0);
        press(4'h1);
        check("hold_idx", 32'(digit_idx_o), 32'd1);
        check("hold_a", a_o, 32'h1);

        // clr after 5 digits of B, with a press overlapping it
        for (int unsigned i = 2; i <= 8; i++) press(4'(i));
        check("a2_value", a_o, 32'h1234_5678);
        for (int unsigned i = 0; i < 5; i++) press(4'hA);
        check("b5_idx", 32'(digit_idx_o), 32'd5);
        check("b5_value", b_o, 32'h000A_AAAA);
        clr_i = 1'b1;
        press(4'hF);
        clr_i = 1'b0;
        @(negedge clk);
        check("clr_phase", 32'(phase_o), 32'h0);
        check("clr_a", a_o, 32'd0);
        check("clr_b", b_o, 32'd0);
        check("clr_idx", 32'(digit_idx_o), 32'd0);

        // operation 2: mul, ALU response withheld
        op_i = 2'b10;
        load(32'hDEAD_BEEF);
        sb_q.push_back('{a: 32'hDEAD_BEEF, b: 32'h0123_4567, op: 2'b10});
        load(32'h0123_4567);
        check("op2_op", 32'(op_o), 32'h2);
        repeat (TMO + 10) @(negedge clk);
`ifdef FP_LOADER_TIMEOUT_EN
        check("tmo_flag", 32'(timeout_o), 32'd1);
        check("tmo_phase", 32'(phase_o), 32'h3);
        check("tmo_busy", 32'(busy_o), 32'd0);
`else
        check("tmo_flag", 32'(timeout_o), 32'd0);
        check("tmo_phase", 32'(phase_o), 32'h2);
        check("tmo_busy", 32'(busy_o), 32'd1);
        pulse_rv();
        check("op2_done_phase", 32'(phase_o), 32'h3);
`endif
        press(4'h0);
        check("op2_restart_phase", 32'(phase_o), 32'h0);
        check("op2_restart_tmo", 32'(timeout_o), 32'd0);
        check("op2_restart_b", b_o, 32'd0);

        // operation 3: div, aborted by reset while waiting
        op_i = 2'b11;
        load(32'hCAFE_F00D);
        sb_q.push_back('{a: 32'hCAFE_F00D, b: 32'h8000_0001, op: 2'b11});
        load(32'h8000_0001);
        check("op3_phase", 32'(phase_o), 32'h2);
        starts_before = n_start;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst_wait");
        reset = 1'b0;
        @(negedge clk);
        pulse_rv();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_after_rv");
        check("rst_no_start", 32'(n_start), 32'(starts_before));

        check("total_starts", 32'(n_start), 32'd3);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_operand_loader.md
FP_OPERAND_LOADER -- requirements
Module: fp_operand_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand width in bits; must be a multiple of 4.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16, stable-high cycles needed to accept a press.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum WAIT duration when timeout is compiled in.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 nibble_i  input  4  hex digit from the switches; sampled when a press is accepted.
REQ-007 enter_i  input  1  raw, asynchronous, bouncing push-button.
REQ-008 clr_i  input  1  synchronous level; abandons the current operation.
REQ-009 op_i  input  2  operation select: 00 add, 01 sub, 10 mul, 11 div.
REQ-010 result_valid_i  input  1  one-cycle pulse from the ALU when its result is ready.
REQ-011 a_o, b_o  output  DATA_WIDTH  assembled operands, driven to the ALU.
REQ-012 op_o  output  2  operation latched at issue.
REQ-013 start_o  output  1  one-cycle issue pulse.
REQ-014 busy_o  output  1  high in ISSUE and WAIT.
REQ-015 phase_o  output  2  00 LOAD_A, 01 LOAD_B, 10 ISSUE/WAIT, 11 DONE.
REQ-016 digit_idx_o  output  $clog2(DATA_WIDTH/4)  number of digits entered for the current operand.
REQ-017 timeout_o  output  1  sticky flag: the ALU did not respond in time.

Function
REQ-018 enter_i SHALL pass a 2-flop synchronizer and then a debouncer; the debounced level rises only after DEBOUNCE_CYCLES consecutive high synchronized samples, and falls on the same rule for low samples.
REQ-019 An accepted press SHALL be a one-cycle pulse on the rising edge of the debounced level; a bounce shorter than DEBOUNCE_CYCLES SHALL produce no press.
REQ-020 The FSM states SHALL be LOAD_A, LOAD_B, ISSUE, WAIT and DONE.
REQ-021 In LOAD_A or LOAD_B, a press SHALL shift the target operand left by 4 and insert nibble_i at bits [3:0] (MSB-first entry) and SHALL increment digit_idx_o.
REQ-022 On the DATA_WIDTH/4-th press in LOAD_A, the FSM SHALL go to LOAD_B and reset digit_idx_o to 0; on the last press in LOAD_B it SHALL go to ISSUE.
REQ-023 ISSUE SHALL last exactly one cycle, assert start_o, latch op_i into op_o and move to WAIT; a_o and b_o stay stable from ISSUE until leaving DONE.
REQ-024 In WAIT, result_valid_i SHALL move the FSM to DONE in the next cycle.
REQ-025 result_valid_i outside WAIT SHALL be ignored.
REQ-026 Presses in ISSUE and WAIT SHALL be ignored.
REQ-027 A press in DONE SHALL clear a_o, b_o, digit_idx_o and timeout_o and return to LOAD_A.
REQ-028 clr_i SHALL force LOAD_A with cleared operands, digit_idx_o and timeout_o from any state; if clr_i and a press occur in the same cycle, clr_i wins and the press is discarded.

Reset
REQ-029 While reset is asserted: state LOAD_A, a_o=b_o=0, op_o=00, start_o=0, busy_o=0, phase_o=00, digit_idx_o=0, timeout_o=0, synchronizer and debounce counter cleared.
REQ-030 Reset asserted mid-operation (including WAIT) SHALL abort with no start_o pulse and no further ALU interaction; a pending result_valid_i is ignored.

Configuration
REQ-031 With FP_LOADER_TIMEOUT_EN defined, a counter SHALL run in WAIT; after TIMEOUT_CYCLES cycles without result_valid_i, the block SHALL set timeout_o and go to DONE.
REQ-032 Without FP_LOADER_TIMEOUT_EN, WAIT SHALL last indefinitely, timeout_o SHALL be tied to 0 and no counter logic SHALL be present.

Structure
REQ-033 Package fp_loader_pkg SHALL hold the state enum, the operation codes (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the phase_o encodings.
REQ-034 The synchronizer and debouncer SHALL be one sub-module, btn_debounce (parameter DEBOUNCE_CYCLES), with outputs level and rise pulse.

Verification
REQ-035 Enter 4,1,4,4,C,C,C,D then 4,0,5,9,9,9,9,A with op_i=00 -> a_o=0x4144CCCD, b_o=0x4059999A, one start_o pulse, op_o=00, busy_o=1.
REQ-036 In WAIT, pulse result_valid_i -> phase_o=11 and busy_o=0 next cycle; a press then gives a_o=0, phase_o=00.
REQ-037 Glitch enter_i high for DEBOUNCE_CYCLES-2 cycles -> digit_idx_o unchanged; hold it for DEBOUNCE_CYCLES+4 cycles -> exactly one digit accepted.
REQ-038 clr_i after 5 digits of B -> phase_o=00, a_o=b_o=0, digit_idx_o=0; a press in the same cycle is not recorded.
REQ-039 With FP_LOADER_TIMEOUT_EN defined, withhold result_valid_i for TIMEOUT_CYCLES cycles -> timeout_o=1, phase_o=11; without the macro -> remains in WAIT.
REQ-040 Assert reset during WAIT, then pulse result_valid_i -> all outputs at reset values, no start_o pulse.
